buffer_out: RTL and testbench
=============================

Name: buffer_out

Overview:
Output-side counterpart of the input byte buffer in the LZW compression datapath. It accepts fixed-width dictionary codes from the controller on its RequestOutBuffer strobe and packs them LSB-first into a continuous bitstream. The bitstream leaves as bytes over a valid/ready handshake to the file/output sink. On CloseBuffer it flushes the residual bits, zero-padded, and then signals completion.

Parameters:
CODE_WIDTH, 12, width of one emitted code in bits (legal range 9..16)
ACC_WIDTH, CODE_WIDTH+7, bit accumulator width; derived, not overridable

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
iCode  input  CODE_WIDTH  code to append to the stream
RequestOutBuffer  input  1  write strobe; iCode is accepted on an edge where RequestOutBuffer=1 and oBusy=0
CloseBuffer  input  1  end-of-stream request, one-cycle pulse or level
oBusy  output  1  code cannot be accepted this cycle
oByte  output  8  output byte
oByteValid  output  1  oByte holds a valid byte
iByteReady  input  1  sink accepts oByte on an edge where oByteValid=1 and iByteReady=1
oDone  output  1  stream fully flushed; sticky until reset
oOverrun  output  1  sticky error: RequestOutBuffer asserted while oBusy=1

Behaviour:
- Reset (sync, active-high) values: acc=0, bitcnt=0, state=RUN, oByte=8'h00, oByteValid=0, oDone=0, oOverrun=0, close_pend=0. Reset overrides everything, including mid-flush and a pending byte; that byte is discarded.
- State machine: RUN -> FLUSH -> DONE.
- Internal registers:
  - acc[ACC_WIDTH-1:0]
  - bitcnt, 0..ACC_WIDTH
  - out_free = !oByteValid || iByteReady
- oBusy = (bitcnt >= 8) || (state != RUN) || close_pend.
- Accept, in RUN when RequestOutBuffer && !oBusy:
  - acc <= acc | (iCode << bitcnt)
  - bitcnt <= bitcnt + CODE_WIDTH
  - Because bitcnt<8 at accept, the result never exceeds ACC_WIDTH bits.
- Emit, any state, when bitcnt >= 8 && out_free:
  - oByte <= acc[7:0]
  - oByteValid <= 1
  - acc <= acc >> 8
  - bitcnt <= bitcnt - 8
- Accept and emit are mutually exclusive: accept requires bitcnt<8, emit requires bitcnt>=8.
- A consumed byte with no replacement clears oByteValid.
- Latency: code accepted at edge N gives its first byte with oByteValid=1 after edge N+1 (output register free). One byte per cycle throughput while iByteReady=1.
- Overrun: RequestOutBuffer=1 while oBusy=1 drops the code and sets oOverrun.
- Close handling:
  - CloseBuffer in RUN sets close_pend.
  - If RequestOutBuffer is accepted in the same cycle, that code is included in the stream.
  - State goes RUN -> FLUSH on the first cycle with close_pend && bitcnt < 8.
- FLUSH:
  - If 0 < bitcnt < 8 and out_free: oByte <= acc[7:0] (upper bits already 0, giving zero-pad), oByteValid <= 1, bitcnt <= 0.
  - When bitcnt==0 and (!oByteValid, or the last byte is consumed this edge): go to DONE.
- DONE: oDone=1, oBusy=1; RequestOutBuffer is ignored (oOverrun still sets); CloseBuffer is ignored. Only reset leaves DONE.
- CloseBuffer with no codes ever written: RUN -> FLUSH -> DONE in 2 cycles, no bytes emitted.
- oByte/oByteValid stay stable while oByteValid=1 && iByteReady=0.

Test Plan:
- Reset, CLOSE-free idle 10 cycles -> oByteValid=0, oBusy=0, oDone=0, oOverrun=0.
- iByteReady=1; write 12'hABC then 12'h123 (each when oBusy=0) -> bytes 8'hBC, 8'h3A, 8'h12 in order; first valid one cycle after the first accept; bitcnt returns to 0.
- Write 12'hFFF then pulse CloseBuffer -> bytes 8'hFF, 8'h0F (zero-padded), then oDone=1; oBusy stays 1.
- Backpressure: iByteReady=0 for 5 cycles after writing 12'hABC -> oByte held at 8'hBC; oBusy=1 while bitcnt>=8; release -> stream resumes with no loss or duplication.
- Write 12'h123 while oBusy=1 -> oOverrun=1, code absent from the stream. Same-cycle RequestOutBuffer(12'h456, accepted) + CloseBuffer -> 8'h56, 8'h04, oDone.
- Reset asserted mid-flush with oByteValid=1 -> next cycle all outputs at reset values. A new write of 12'h001 then emits 8'h01.

Source files
------------

// File: rtl/buffer_out.sv
// buffer_out: packs fixed-width LZW codes LSB-first into a byte stream.
// Flushes zero-padded residual bits on close, then reports completion.
module buffer_out #(
   parameter int CODE_WIDTH = 12
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [CODE_WIDTH-1:0] iCode,
   input  logic                  RequestOutBuffer,
   input  logic                  CloseBuffer,
   output logic                  oBusy,
   output logic [7:0]            oByte,
   output logic                  oByteValid,
   input  logic                  iByteReady,
   output logic                  oDone,
   output logic                  oOverrun
);

   localparam int ACC_WIDTH = CODE_WIDTH + 7;
   localparam int CW        = $clog2(ACC_WIDTH + 1);

   typedef enum logic [1:0] {
      RUN,
      FLUSH,
      DONE
   } state_t;

   state_t               state;
   logic [ACC_WIDTH-1:0] acc;
   logic [CW-1:0]        bitcnt;
   logic                 close_pend;

   logic                 out_free;
   logic                 consumed;
   logic                 have_byte;
   logic                 accept;
   logic                 emit;
   logic                 partial;
   logic                 last_gone;
   logic [ACC_WIDTH-1:0] code_ext;

   assign out_free  = !oByteValid || iByteReady;
   assign consumed  = oByteValid && iByteReady;
   assign have_byte = bitcnt >= CW'(8);
   assign oBusy     = have_byte || (state != RUN) || close_pend;
   assign accept    = (state == RUN) && RequestOutBuffer && !oBusy;
   assign emit      = have_byte && out_free;
   assign partial   = (state == FLUSH) && (bitcnt != '0)
                      && !have_byte && out_free;
   assign last_gone = (bitcnt == '0) && (!oByteValid || consumed);
   assign code_ext  = ACC_WIDTH'(iCode);

   // Accumulator, output byte register and RUN/FLUSH/DONE sequencing
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= RUN;
         acc        <= '0;
         bitcnt     <= '0;
         close_pend <= 1'b0;
         oByte      <= 8'h00;
         oByteValid <= 1'b0;
         oDone      <= 1'b0;
         oOverrun   <= 1'b0;
      end else begin
         if (consumed)
            oByteValid <= 1'b0;

         if (RequestOutBuffer && oBusy)
            oOverrun <= 1'b1;

         if (accept) begin
            acc    <= acc | (code_ext << bitcnt);
            bitcnt <= bitcnt + CW'(CODE_WIDTH);
         end else if (emit) begin
            oByte      <= acc[7:0];
            oByteValid <= 1'b1;
            acc        <= acc >> 8;
            bitcnt     <= bitcnt - CW'(8);
         end else if (partial) begin
            oByte      <= acc[7:0];
            oByteValid <= 1'b1;
            acc        <= '0;
            bitcnt     <= '0;
         end

         unique case (state)
            RUN: begin
               if (CloseBuffer)
                  close_pend <= 1'b1;
               if (close_pend && !have_byte)
                  state <= FLUSH;
            end
            FLUSH: begin
               if (last_gone) begin
                  state <= DONE;
                  oDone <= 1'b1;
               end
            end
            DONE: begin
               oDone <= 1'b1;
            end
            default: begin
               state <= RUN;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_buffer_out.sv
// tb_buffer_out: table-driven and directed checks of buffer_out.
// Expected bytes go to a queue when codes are written; popped on handshake.
module tb_buffer_out;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [11:0] iCode = '0;
   logic        RequestOutBuffer = 1'b0;
   logic        CloseBuffer = 1'b0;
   logic        iByteReady = 1'b1;
   logic        oBusy;
   logic [7:0]  oByte;
   logic        oByteValid;
   logic        oDone;
   logic        oOverrun;

   int          n_checks = 0;
   int          n_pass = 0;
   logic [7:0]  sb[$];
   logic [7:0]  exp_b;

   typedef struct {
      logic [11:0] c0;
      logic [11:0] c1;
      logic [7:0]  b0;
      logic [7:0]  b1;
      logic [7:0]  b2;
   } vec_t;

   vec_t vecs[6];

   buffer_out #(.CODE_WIDTH(12)) dut (
      .clk              (clk),
      .reset            (reset),
      .iCode            (iCode),
      .RequestOutBuffer (RequestOutBuffer),
      .CloseBuffer      (CloseBuffer),
      .oBusy            (oBusy),
      .oByte            (oByte),
      .oByteValid       (oByteValid),
      .iByteReady       (iByteReady),
      .oDone            (oDone),
      .oOverrun         (oOverrun)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_checks++;
      if (act === exp)
         n_pass++;
      else
         $display("FAIL %s: got %0h required %0h", name, act, exp);
   endtask

   // Scoreboard: each accepted byte must match the head of the queue
   always @(negedge clk) begin
      if (!reset && oByteValid && iByteReady) begin
         if (sb.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_byte: got %02h required none", oByte);
         end else begin
            exp_b = sb.pop_front();
            chk("stream_byte", {24'h0, oByte}, {24'h0, exp_b});
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout required finish");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      RequestOutBuffer = 1'b0;
      CloseBuffer = 1'b0;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      sb.delete();
   endtask

   task automatic write_code(input logic [11:0] c, input logic cl);
      int t = 0;
      while (oBusy && t < 100) begin
         tick();
         t++;
      end
      if (oBusy) begin
         n_checks++;
         $display("FAIL write_wait: got busy required idle");
      end
      iCode = c;
      RequestOutBuffer = 1'b1;
      CloseBuffer = cl;
      tick();
      RequestOutBuffer = 1'b0;
      CloseBuffer = 1'b0;
   endtask

   task automatic drain();
      int t = 0;
      while ((sb.size() != 0 || oByteValid) && t < 200) begin
         tick();
         t++;
      end
      chk("drain_left", sb.size(), 0);
   endtask

   task automatic wait_done();
      int t = 0;
      while (!oDone && t < 200) begin
         tick();
         t++;
      end
      chk("done", {31'h0, oDone}, 1);
   endtask

   initial begin
      vecs[0] = '{12'hABC, 12'h123, 8'hBC, 8'h3A, 8'h12};
      vecs[1] = '{12'hFFF, 12'h000, 8'hFF, 8'h0F, 8'h00};
      vecs[2] = '{12'h001, 12'h800, 8'h01, 8'h00, 8'h80};
      vecs[3] = '{12'h5A5, 12'hA5A, 8'hA5, 8'hA5, 8'hA5};
      vecs[4] = '{12'h000, 12'hFFF, 8'h00, 8'hF0, 8'hFF};
      vecs[5] = '{12'h345, 12'h678, 8'h45, 8'h83, 8'h67};

      tick();
      tick();
      reset = 1'b0;
      repeat (10) tick();
      chk("idle_valid", {31'h0, oByteValid}, 0);
      chk("idle_busy", {31'h0, oBusy}, 0);
      chk("idle_done", {31'h0, oDone}, 0);
      chk("idle_overrun", {31'h0, oOverrun}, 0);
      chk("idle_byte", {24'h0, oByte}, 0);

      sb.push_back(8'hBC);
      sb.push_back(8'h3A);
      sb.push_back(8'h12);
      write_code(12'hABC, 1'b0);
      chk("lat_edge_n", {31'h0, oByteValid}, 0);
      tick();
      chk("lat_edge_n1_valid", {31'h0, oByteValid}, 1);
      chk("lat_edge_n1_byte", {24'h0, oByte}, 32'hBC);
      write_code(12'h123, 1'b0);
      drain();
      chk("pair_busy", {31'h0, oBusy}, 0);

      for (int i = 0; i < 6; i++) begin
         sb.push_back(vecs[i].b0);
         sb.push_back(vecs[i].b1);
         sb.push_back(vecs[i].b2);
         write_code(vecs[i].c0, 1'b0);
         write_code(vecs[i].c1, 1'b0);
         drain();
      end

      iByteReady = 1'b0;
      sb.push_back(8'hBC);
      sb.push_back(8'h3A);
      sb.push_back(8'h12);
      write_code(12'hABC, 1'b0);
      tick();
      for (int i = 0; i < 5; i++) begin
         chk("bp_hold_valid", {31'h0, oByteValid}, 1);
         chk("bp_hold_byte", {24'h0, oByte}, 32'hBC);
         tick();
      end
      write_code(12'h123, 1'b0);
      chk("bp_busy", {31'h0, oBusy}, 1);
      tick();
      chk("bp_busy_held", {31'h0, oBusy}, 1);
      chk("bp_byte_held", {24'h0, oByte}, 32'hBC);
      iByteReady = 1'b1;
      drain();

      chk("ovr_pre", {31'h0, oOverrun}, 0);
      sb.push_back(8'h89);
      sb.push_back(8'hC7);
      sb.push_back(8'hAB);
      write_code(12'h789, 1'b0);
      chk("ovr_busy", {31'h0, oBusy}, 1);
      iCode = 12'h123;
      RequestOutBuffer = 1'b1;
      tick();
      RequestOutBuffer = 1'b0;
      chk("overrun", {31'h0, oOverrun}, 1);
      write_code(12'hABC, 1'b0);
      drain();

      sb.push_back(8'h56);
      sb.push_back(8'h04);
      write_code(12'h456, 1'b1);
      wait_done();
      chk("close_busy", {31'h0, oBusy}, 1);
      chk("close_sb", sb.size(), 0);
      iCode = 12'h3FF;
      RequestOutBuffer = 1'b1;
      CloseBuffer = 1'b1;
      repeat (3) tick();
      RequestOutBuffer = 1'b0;
      CloseBuffer = 1'b0;
      tick();
      chk("done_ignore_valid", {31'h0, oByteValid}, 0);
      chk("done_sticky", {31'h0, oDone}, 1);

      do_reset();
      sb.push_back(8'hFF);
      sb.push_back(8'h0F);
      write_code(12'hFFF, 1'b0);
      CloseBuffer = 1'b1;
      tick();
      CloseBuffer = 1'b0;
      wait_done();
      chk("fff_busy", {31'h0, oBusy}, 1);
      chk("fff_sb", sb.size(), 0);
      tick();
      chk("fff_done_sticky", {31'h0, oDone}, 1);

      do_reset();
      CloseBuffer = 1'b1;
      tick();
      CloseBuffer = 1'b0;
      chk("empty_c0_done", {31'h0, oDone}, 0);
      chk("empty_c0_busy", {31'h0, oBusy}, 1);
      tick();
      chk("empty_c1_done", {31'h0, oDone}, 0);
      tick();
      chk("empty_c2_done", {31'h0, oDone}, 1);
      chk("empty_valid", {31'h0, oByteValid}, 0);

      do_reset();
      iByteReady = 1'b0;
      write_code(12'hFFF, 1'b0);
      CloseBuffer = 1'b1;
      tick();
      CloseBuffer = 1'b0;
      repeat (3) tick();
      chk("midflush_valid", {31'h0, oByteValid}, 1);
      chk("midflush_done", {31'h0, oDone}, 0);
      do_reset();
      chk("rst_valid", {31'h0, oByteValid}, 0);
      chk("rst_byte", {24'h0, oByte}, 0);
      chk("rst_done", {31'h0, oDone}, 0);
      chk("rst_busy", {31'h0, oBusy}, 0);
      chk("rst_overrun", {31'h0, oOverrun}, 0);
      iByteReady = 1'b1;
      sb.push_back(8'h01);
      write_code(12'h001, 1'b0);
      drain();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
